// File: rtl/aurora_traffic_gen.sv
// Per-lane AXI4-Stream frame generator and checker for an Aurora 64B66B channel.
// Optional build macro AURORA_TG_ERR_INJECT_EN adds i_err_inject.
module aurora_traffic_gen #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_FRAME_LEN  = 128,
  parameter int P_GAP_CYCLES = 4,
  parameter int P_CNT_WIDTH  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic                      i_channel_up,
`ifdef AURORA_TG_ERR_INJECT_EN
  input  logic                      i_err_inject,
`endif
  output logic [P_DATA_WIDTH-1:0]   m_axi_tx_tdata,
  output logic [P_DATA_WIDTH/8-1:0] m_axi_tx_tkeep,
  output logic                      m_axi_tx_tlast,
  output logic                      m_axi_tx_tvalid,
  input  logic                      m_axi_tx_tready,
  input  logic [P_DATA_WIDTH-1:0]   s_axi_rx_tdata,
  input  logic [P_DATA_WIDTH/8-1:0] s_axi_rx_tkeep,
  input  logic                      s_axi_rx_tlast,
  input  logic                      s_axi_rx_tvalid,
  output logic [P_CNT_WIDTH-1:0]    o_tx_frame_cnt,
  output logic [P_CNT_WIDTH-1:0]    o_rx_frame_cnt,
  output logic [P_CNT_WIDTH-1:0]    o_err_cnt,
  output logic                      o_err,
  output logic                      o_rx_locked
);

  localparam int H  = P_DATA_WIDTH / 2;
  localparam int BW = 16;
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_FRAME_LEN - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(P_GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_e;

  tx_state_e              state_q, state_d;
  logic [H-1:0]           tx_seq_q, tx_seq_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [BW-1:0]          gap_q, gap_d;
  logic [P_CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic                   inj_q, inj_d;

  logic                   locked_q, locked_d;
  logic                   resync_q, resync_d;
  logic                   bad_q, bad_d;
  logic                   err_q, err_d;
  logic [H-1:0]           exp_seq_q, exp_seq_d;
  logic [BW-1:0]          exp_beat_q, exp_beat_d;
  logic [P_CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [P_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic         tx_xfer, tx_last, gap_done;
  logic [H-1:0] rx_s, rx_b;
  logic         hunting, mism, exp_last, len_err;
  logic [1:0]   n_err;
  logic         unused_rx_tkeep;

  function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
    logic [P_CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(P_CNT_WIDTH-1){1'b0}}, inc};
    return s[P_CNT_WIDTH] ? '1 : s[P_CNT_WIDTH-1:0];
  endfunction

  assign unused_rx_tkeep = &s_axi_rx_tkeep;
  assign tx_xfer  = (state_q == S_SEND) & m_axi_tx_tready & i_channel_up;
  assign tx_last  = (beat_q == LAST_BEAT);
  assign gap_done = (gap_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    if (!i_channel_up) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_enable) state_d = S_SEND;
        S_SEND: begin
          if (tx_xfer && tx_last) begin
            if (P_GAP_CYCLES > 0) state_d = S_GAP;
            else                  state_d = i_enable ? S_SEND : S_IDLE;
          end
        end
        S_GAP:   if (gap_done) state_d = i_enable ? S_SEND : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A dropped link abandons the partial frame but keeps tx_seq, so the frame is resent.
  always_comb begin
    tx_seq_d = tx_seq_q;
    beat_d   = beat_q;
    tx_cnt_d = tx_cnt_q;
    gap_d    = (state_q == S_GAP) ? gap_q + 1'b1 : '0;
    if (!i_channel_up) begin
      beat_d = '0;
    end else if (tx_xfer) begin
      if (tx_last) begin
        beat_d   = '0;
        tx_seq_d = tx_seq_q + 1'b1;
        tx_cnt_d = sat_add(tx_cnt_q, 2'd1);
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
`ifdef AURORA_TG_ERR_INJECT_EN
    inj_d = inj_q ? ~tx_xfer : i_err_inject;
`else
    inj_d = 1'b0;
`endif
  end

  always_comb begin
    m_axi_tx_tvalid = (state_q == S_SEND);
    m_axi_tx_tdata  = {tx_seq_q, H'(beat_q)};
    m_axi_tx_tdata[0] = m_axi_tx_tdata[0] ^ inj_q;
    m_axi_tx_tkeep  = m_axi_tx_tvalid ? '1 : '0;
    m_axi_tx_tlast  = m_axi_tx_tvalid & tx_last;
  end

  assign rx_s     = s_axi_rx_tdata[P_DATA_WIDTH-1:H];
  assign rx_b     = s_axi_rx_tdata[H-1:0];
  assign hunting  = ~locked_q | resync_q;
  assign mism     = (rx_s != exp_seq_q) | (rx_b != H'(exp_beat_q));
  assign exp_last = (exp_beat_q == LAST_BEAT);
  assign len_err  = s_axi_rx_tlast ^ exp_last;
  assign n_err    = {1'b0, mism} + {1'b0, len_err};

  always_comb begin
    locked_d   = locked_q;
    resync_d   = resync_q;
    bad_d      = bad_q;
    err_d      = err_q;
    exp_seq_d  = exp_seq_q;
    exp_beat_d = exp_beat_q;
    rx_cnt_d   = rx_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (!i_channel_up) begin
      locked_d = 1'b0;
      resync_d = 1'b0;
      bad_d    = 1'b0;
    end else if (s_axi_rx_tvalid) begin
      if (hunting) begin
        if (rx_b == '0) begin
          locked_d = 1'b1;
          resync_d = 1'b0;
          bad_d    = 1'b0;
          if (P_FRAME_LEN == 1) begin
            exp_seq_d  = rx_s + 1'b1;
            exp_beat_d = '0;
            if (s_axi_rx_tlast) rx_cnt_d = sat_add(rx_cnt_q, 2'd1);
          end else begin
            exp_seq_d  = rx_s;
            exp_beat_d = BW'(1);
          end
        end
      end else begin
        err_cnt_d = sat_add(err_cnt_q, n_err);
        err_d     = err_q | (n_err != 2'd0);
        if (s_axi_rx_tlast) begin
          if (!bad_q && n_err == 2'd0) rx_cnt_d = sat_add(rx_cnt_q, 2'd1);
          exp_beat_d = '0;
          exp_seq_d  = exp_seq_q + 1'b1;
          bad_d      = 1'b0;
        end else if (exp_last) begin
          // Missing tlast: wait for the next beat-0 to realign.
          resync_d = 1'b1;
          bad_d    = 1'b0;
        end else begin
          exp_beat_d = exp_beat_q + 1'b1;
          bad_d      = bad_q | mism;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tx_seq_q   <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      tx_cnt_q   <= '0;
      inj_q      <= 1'b0;
      locked_q   <= 1'b0;
      resync_q   <= 1'b0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      exp_seq_q  <= '0;
      exp_beat_q <= '0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_seq_q   <= tx_seq_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      tx_cnt_q   <= tx_cnt_d;
      inj_q      <= inj_d;
      locked_q   <= locked_d;
      resync_q   <= resync_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      exp_seq_q  <= exp_seq_d;
      exp_beat_q <= exp_beat_d;
      rx_cnt_q   <= rx_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_tx_frame_cnt = tx_cnt_q;
  assign o_rx_frame_cnt = rx_cnt_q;
  assign o_err_cnt      = err_cnt_q;
  assign o_err          = err_q;
  assign o_rx_locked    = locked_q;

endmodule

// File: tb/tb_aurora_traffic_gen.sv
// Directed bench for aurora_traffic_gen: 64-bit, 4-beat frames, 2-cycle gap.
module tb_aurora_traffic_gen;
  localparam int DW = 64;
  localparam int FL = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, enable, up, tready, lb;
  logic [DW-1:0] tx_tdata, rx_tdata, d_dat;
  logic [7:0]    tx_tkeep, rx_tkeep;
  logic          tx_tlast, tx_tvalid, rx_tlast, rx_tvalid, d_vld, d_last;
  logic [CW-1:0] tx_cnt, rx_cnt, err_cnt;
  logic          err, locked;
`ifdef AURORA_TG_ERR_INJECT_EN
  logic          err_inject;
`endif

  always #5 clk = ~clk;

  assign rx_tdata  = lb ? tx_tdata : d_dat;
  assign rx_tvalid = lb ? (tx_tvalid & tready) : d_vld;
  assign rx_tlast  = lb ? tx_tlast : d_last;
  assign rx_tkeep  = 8'hFF;

  aurora_traffic_gen #(.P_DATA_WIDTH(DW), .P_FRAME_LEN(FL), .P_GAP_CYCLES(2), .P_CNT_WIDTH(CW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(enable),
    .i_channel_up(up),
`ifdef AURORA_TG_ERR_INJECT_EN
    .i_err_inject(err_inject),
`endif
    .m_axi_tx_tdata(tx_tdata),
    .m_axi_tx_tkeep(tx_tkeep),
    .m_axi_tx_tlast(tx_tlast),
    .m_axi_tx_tvalid(tx_tvalid),
    .m_axi_tx_tready(tready),
    .s_axi_rx_tdata(rx_tdata),
    .s_axi_rx_tkeep(rx_tkeep),
    .s_axi_rx_tlast(rx_tlast),
    .s_axi_rx_tvalid(rx_tvalid),
    .o_tx_frame_cnt(tx_cnt),
    .o_rx_frame_cnt(rx_cnt),
    .o_err_cnt(err_cnt),
    .o_err(err),
    .o_rx_locked(locked)
  );

  typedef struct {
    logic        vld;
    logic [31:0] s;
    logic [31:0] b;
    logic        last;
    int          err;
    int          frm;
    logic        lck;
  } rxvec_t;

  rxvec_t        vt[29];
  int            errors = 0;
  int            checks = 0;
  int            k;
  logic          stall;
  logic [DW-1:0] pdat;
  logic          plast;

  function automatic rxvec_t mk(input logic v, input int s, input int b, input logic l,
                                input int e, input int f, input logic lk);
    rxvec_t r;
    r.vld = v; r.s = s; r.b = b; r.last = l; r.err = e; r.frm = f; r.lck = lk;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget, input string nm);
    int c = 0;
    while (tx_cnt != CW'(n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, DW'(tx_cnt), DW'(n));
  endtask

  task automatic wait_vld(input int budget, input string nm);
    int c = 0;
    while (!tx_tvalid && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, DW'(tx_tvalid), 64'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tvalid"}, DW'(tx_tvalid), 64'd0);
    chk({nm, "_tdata"}, tx_tdata, 64'd0);
    chk({nm, "_tkeep"}, DW'(tx_tkeep), 64'd0);
    chk({nm, "_tlast"}, DW'(tx_tlast), 64'd0);
    chk({nm, "_txcnt"}, DW'(tx_cnt), 64'd0);
    chk({nm, "_rxcnt"}, DW'(rx_cnt), 64'd0);
    chk({nm, "_errcnt"}, DW'(err_cnt), 64'd0);
    chk({nm, "_err"}, DW'(err), 64'd0);
    chk({nm, "_locked"}, DW'(locked), 64'd0);
  endtask

  initial begin
    vt[0]  = mk(1, 7, 2, 0, 0, 0, 0);  vt[1]  = mk(1, 7, 3, 1, 0, 0, 0);
    vt[2]  = mk(1, 8, 0, 0, 0, 0, 1);  vt[3]  = mk(0, 0, 0, 0, 0, 0, 1);
    vt[4]  = mk(1, 8, 1, 0, 0, 0, 1);  vt[5]  = mk(1, 8, 2, 0, 0, 0, 1);
    vt[6]  = mk(1, 8, 3, 1, 0, 1, 1);  vt[7]  = mk(1, 9, 0, 0, 0, 1, 1);
    vt[8]  = mk(1, 9, 1, 0, 0, 1, 1);  vt[9]  = mk(1, 9, 2, 1, 1, 1, 1);
    vt[10] = mk(1, 10, 0, 0, 1, 1, 1); vt[11] = mk(1, 10, 1, 0, 1, 1, 1);
    vt[12] = mk(1, 10, 2, 0, 1, 1, 1); vt[13] = mk(1, 10, 3, 1, 1, 2, 1);
    vt[14] = mk(1, 12, 0, 0, 2, 2, 1); vt[15] = mk(1, 11, 1, 0, 2, 2, 1);
    vt[16] = mk(1, 11, 2, 0, 2, 2, 1); vt[17] = mk(1, 11, 3, 1, 2, 2, 1);
    vt[18] = mk(1, 12, 0, 1, 3, 2, 1); vt[19] = mk(1, 99, 0, 1, 5, 2, 1);
    vt[20] = mk(1, 14, 0, 0, 5, 2, 1); vt[21] = mk(1, 14, 1, 0, 5, 2, 1);
    vt[22] = mk(1, 14, 2, 0, 5, 2, 1); vt[23] = mk(1, 14, 3, 0, 6, 2, 1);
    vt[24] = mk(1, 14, 5, 0, 6, 2, 1); vt[25] = mk(1, 20, 0, 0, 6, 2, 1);
    vt[26] = mk(1, 20, 1, 0, 6, 2, 1); vt[27] = mk(1, 20, 2, 0, 6, 2, 1);
    vt[28] = mk(1, 20, 3, 1, 6, 3, 1);

    rst_n = 1'b0; enable = 1'b0; up = 1'b0; tready = 1'b0; lb = 1'b1;
    d_dat = '0; d_vld = 1'b0; d_last = 1'b0;
`ifdef AURORA_TG_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Loopback, 10 frames with full throughput.
    up = 1'b1; tready = 1'b1; enable = 1'b1;
    wait_vld(20, "lb_first_vld");
    chk("lb_first_tdata", tx_tdata, 64'd0);
    chk("lb_first_tkeep", DW'(tx_tkeep), 64'hFF);
    chk("lb_first_tlast", DW'(tx_tlast), 64'd0);
    for (int b = 1; b < FL; b++) begin
      @(negedge clk);
      chk("lb_beat_tdata", tx_tdata, DW'(b));
      chk("lb_beat_tlast", DW'(tx_tlast), DW'(b == FL - 1));
    end
    wait_tx(10, 300, "lb_tx_cnt");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("lb_rx_cnt", DW'(rx_cnt), 64'd10);
    chk("lb_err_cnt", DW'(err_cnt), 64'd0);
    chk("lb_err", DW'(err), 64'd0);

    // Random backpressure for 100 more frames; data must hold while stalled.
    enable = 1'b1; stall = 1'b0; k = 0;
    while (tx_cnt != CW'(110) && k < 20000) begin
      @(negedge clk);
      k++;
      if (stall) begin
        chk("bp_stable_tdata", tx_tdata, pdat);
        chk("bp_stable_tlast", DW'(tx_tlast), DW'(plast));
      end
      tready = 1'($urandom_range(0, 1));
      stall  = tx_tvalid & ~tready;
      pdat   = tx_tdata;
      plast  = tx_tlast;
    end
    enable = 1'b0; tready = 1'b1;
    chk("bp_tx_cnt", DW'(tx_cnt), 64'd110);
    repeat (5) @(negedge clk);
    chk("bp_rx_cnt", DW'(rx_cnt), 64'd110);
    chk("bp_err_cnt", DW'(err_cnt), 64'd0);

    // Link drop at beat 2 of seq 5, then resend of seq 5 from beat 0.
    do_reset();
    enable = 1'b1;
    wait_tx(5, 300, "cu_tx_cnt5");
    k = 0;
    while (!(tx_tvalid && tx_tdata == {32'd5, 32'd2}) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cu_beat2", tx_tdata, {32'd5, 32'd2});
    up = 1'b0;
    @(negedge clk);
    chk("cu_tvalid_low", DW'(tx_tvalid), 64'd0);
    chk("cu_unlocked", DW'(locked), 64'd0);
    chk("cu_tx_cnt_kept", DW'(tx_cnt), 64'd5);
    repeat (3) @(negedge clk);
    up = 1'b1;
    wait_vld(20, "cu_resume_vld");
    chk("cu_resend", tx_tdata, {32'd5, 32'd0});
    wait_tx(8, 300, "cu_tx_cnt8");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("cu_rx_cnt", DW'(rx_cnt), 64'd8);
    chk("cu_err_cnt", DW'(err_cnt), 64'd0);
    chk("cu_relocked", DW'(locked), 64'd1);

    // Directed RX vectors: early/missing tlast, mismatches, double errors.
    do_reset();
    lb = 1'b0;
    for (int i = 0; i < 29; i++) begin
      d_vld = vt[i].vld; d_dat = {vt[i].s, vt[i].b}; d_last = vt[i].last;
      @(negedge clk);
      chk($sformatf("rx%0d_errcnt", i), DW'(err_cnt), DW'(vt[i].err));
      chk($sformatf("rx%0d_frmcnt", i), DW'(rx_cnt), DW'(vt[i].frm));
      chk($sformatf("rx%0d_locked", i), DW'(locked), DW'(vt[i].lck));
      chk($sformatf("rx%0d_err", i), DW'(err), DW'(vt[i].err != 0));
    end
    d_vld = 1'b0;
    lb = 1'b1;

`ifdef AURORA_TG_ERR_INJECT_EN
    // One injection pulse corrupts exactly one transferred beat.
    do_reset();
    enable = 1'b1;
    begin
      logic [31:0] ms, mb;
      int flips;
      ms = 0; mb = 0; flips = 0; k = 0;
      while (tx_cnt != CW'(6) && k < 500) begin
        @(negedge clk);
        k++;
        if (tx_tvalid) begin
          if (tx_tdata != {ms, mb}) flips++;
          mb++;
          if (mb == FL) begin mb = 0; ms++; end
        end
        err_inject = (k == 15);
      end
      enable = 1'b0; err_inject = 1'b0;
      repeat (5) @(negedge clk);
      chk("inj_flips", DW'(flips), 64'd1);
      chk("inj_tx_cnt", DW'(tx_cnt), 64'd6);
      chk("inj_err_cnt", DW'(err_cnt), 64'd1);
      chk("inj_err", DW'(err), 64'd1);
      chk("inj_rx_cnt", DW'(rx_cnt), 64'd5);
    end
`endif

    // Asynchronous reset mid-frame, then relock.
    do_reset();
    enable = 1'b1;
    wait_tx(1, 100, "ar_tx_cnt1");
    wait_vld(20, "ar_vld");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_unlocked", DW'(locked), 64'd0);
    k = 0;
    while (!locked && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ar_relock", DW'(locked), 64'd1);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_err_cnt", DW'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
